imm_gen_stage: RTL and testbench

Parametrised, pipelined immediate generator for the decode stage. Takes a 32-bit RISC-V instruction with an explicit or self-decoded format selector and produces the XLEN-wide immediate one cycle later. The registered output sits behind a 2-entry skid buffer with valid/ready on both sides, so ID→EX backpressure never creates a combinational ready path. It supports RV32/RV64, shift-amount extraction, illegal-format flagging and pipeline flush.

---
 rtl/imm_gen_pkg.sv | 33 +++
 rtl/imm_gen_core.sv | 94 +++++++++
 rtl/imm_gen_stage.sv | 117 +++++++++++
 tb/tb_imm_gen_stage.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/imm_gen_pkg.sv
// Shared types and constants for the immediate generator.
// Optional feature macro: IMM_GEN_ZIMM_EN (Z-format CSR immediate).
package imm_gen_pkg;

  typedef enum logic [2:0] {
    FMT_I     = 3'b000,
    FMT_S     = 3'b001,
    FMT_B     = 3'b010,
    FMT_J     = 3'b011,
    FMT_U     = 3'b100,
    FMT_Z     = 3'b101,
    FMT_SHAMT = 3'b110,
    FMT_NONE  = 3'b111
  } imm_fmt_e;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;

  function automatic int unsigned shamt_width(input int unsigned xlen);
    return (xlen == 32'd64) ? 32'd6 : 32'd5;
  endfunction

endpackage

// File: rtl/imm_gen_core.sv
// Combinational format selection and immediate extension.
// Optional feature macro: IMM_GEN_ZIMM_EN (Z-format CSR immediate).
module imm_gen_core
  import imm_gen_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int AUTO_DECODE = 0
) (
  input  logic [31:0]     instr_i,
  input  logic [2:0]      imm_src_i,
  output logic [XLEN-1:0] imm_o,
  output logic            illegal_o
);

  localparam int SW = int'(shamt_width(XLEN));

  logic [6:0] opcode_s;
  logic [2:0] funct3_s;
  imm_fmt_e   fmt_s;
  logic       illegal_s;

  assign opcode_s = instr_i[6:0];
  assign funct3_s = instr_i[14:12];

  always_comb begin
    fmt_s     = FMT_NONE;
    illegal_s = 1'b0;
    if (AUTO_DECODE != 0) begin
      case (opcode_s)
        OPC_LOAD, OPC_JALR: fmt_s = FMT_I;
        OPC_OP_IMM: fmt_s = (funct3_s == 3'b001 || funct3_s == 3'b101) ? FMT_SHAMT : FMT_I;
        OPC_OP_IMM_32: begin
          if (XLEN == 64) begin
            fmt_s = (funct3_s == 3'b001 || funct3_s == 3'b101) ? FMT_SHAMT : FMT_I;
          end else begin
            illegal_s = 1'b1;
          end
        end
        OPC_STORE:          fmt_s = FMT_S;
        OPC_BRANCH:         fmt_s = FMT_B;
        OPC_JAL:            fmt_s = FMT_J;
        OPC_LUI, OPC_AUIPC: fmt_s = FMT_U;
        OPC_SYSTEM: begin
`ifdef IMM_GEN_ZIMM_EN
          fmt_s = funct3_s[2] ? FMT_Z : FMT_I;
`else
          fmt_s = FMT_I;
`endif
        end
        OPC_OP: fmt_s = FMT_NONE;
        OPC_OP_32: begin
          if (XLEN == 64) begin
            fmt_s = FMT_NONE;
          end else begin
            illegal_s = 1'b1;
          end
        end
        default: illegal_s = 1'b1;
      endcase
    end else begin
      fmt_s = imm_fmt_e'(imm_src_i);
    end
  end

  // An illegal format forces a zero immediate via the NONE path.
  always_comb begin
    imm_o = {XLEN{1'b0}};
    if (illegal_s) begin
      imm_o = {XLEN{1'b0}};
    end else begin
      case (fmt_s)
        FMT_I: imm_o = {{(XLEN-12){instr_i[31]}}, instr_i[31:20]};
        FMT_S: imm_o = {{(XLEN-12){instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
        FMT_B: imm_o = {{(XLEN-12){instr_i[31]}}, instr_i[7], instr_i[30:25],
                        instr_i[11:8], 1'b0};
        FMT_J: imm_o = {{(XLEN-20){instr_i[31]}}, instr_i[19:12], instr_i[20],
                        instr_i[30:21], 1'b0};
        FMT_U: imm_o = {{(XLEN-32){instr_i[31]}}, instr_i[31:12], 12'h000};
        FMT_Z: begin
`ifdef IMM_GEN_ZIMM_EN
          imm_o = {{(XLEN-5){1'b0}}, instr_i[19:15]};
`else
          imm_o = {XLEN{1'b0}};
`endif
        end
        FMT_SHAMT: imm_o = {{(XLEN-SW){1'b0}}, instr_i[20+SW-1:20]};
        default:   imm_o = {XLEN{1'b0}};
      endcase
    end
  end

  assign illegal_o = illegal_s;

endmodule

// File: rtl/imm_gen_stage.sv
// Pipelined immediate generator: output register plus skid register.
// Optional feature macro: IMM_GEN_ZIMM_EN (Z-format CSR immediate).
module imm_gen_stage
  import imm_gen_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int TAG_W       = 32,
  parameter int AUTO_DECODE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [2:0]       in_imm_src,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  logic [XLEN-1:0]  core_imm_s;
  logic             core_ill_s;

  logic             o_valid_q, o_valid_d;
  logic [XLEN-1:0]  o_imm_q,   o_imm_d;
  logic [TAG_W-1:0] o_tag_q,   o_tag_d;
  logic             o_ill_q,   o_ill_d;
  logic             k_valid_q, k_valid_d;
  logic [XLEN-1:0]  k_imm_q,   k_imm_d;
  logic [TAG_W-1:0] k_tag_q,   k_tag_d;
  logic             k_ill_q,   k_ill_d;

  logic accept_s;
  logic consume_s;

  imm_gen_core #(
    .XLEN        (XLEN),
    .AUTO_DECODE (AUTO_DECODE)
  ) u_core (
    .instr_i   (in_instr),
    .imm_src_i (in_imm_src),
    .imm_o     (core_imm_s),
    .illegal_o (core_ill_s)
  );

  assign accept_s  = in_valid && !k_valid_q;
  assign consume_s = o_valid_q && out_ready;

  // K can only be full while in_ready is low, so accept and K->O never coincide.
  always_comb begin
    o_valid_d = o_valid_q;
    o_imm_d   = o_imm_q;
    o_tag_d   = o_tag_q;
    o_ill_d   = o_ill_q;
    k_valid_d = k_valid_q;
    k_imm_d   = k_imm_q;
    k_tag_d   = k_tag_q;
    k_ill_d   = k_ill_q;
    if (flush) begin
      o_valid_d = 1'b0;
      k_valid_d = 1'b0;
    end else if (consume_s && k_valid_q) begin
      o_valid_d = 1'b1;
      o_imm_d   = k_imm_q;
      o_tag_d   = k_tag_q;
      o_ill_d   = k_ill_q;
      k_valid_d = 1'b0;
    end else if (accept_s && (!o_valid_q || consume_s)) begin
      o_valid_d = 1'b1;
      o_imm_d   = core_imm_s;
      o_tag_d   = in_tag;
      o_ill_d   = core_ill_s;
    end else if (accept_s) begin
      k_valid_d = 1'b1;
      k_imm_d   = core_imm_s;
      k_tag_d   = in_tag;
      k_ill_d   = core_ill_s;
    end else if (consume_s) begin
      o_valid_d = 1'b0;
    end else begin
      o_valid_d = o_valid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid_q <= 1'b0;
      o_imm_q   <= {XLEN{1'b0}};
      o_tag_q   <= {TAG_W{1'b0}};
      o_ill_q   <= 1'b0;
      k_valid_q <= 1'b0;
      k_imm_q   <= {XLEN{1'b0}};
      k_tag_q   <= {TAG_W{1'b0}};
      k_ill_q   <= 1'b0;
    end else begin
      o_valid_q <= o_valid_d;
      o_imm_q   <= o_imm_d;
      o_tag_q   <= o_tag_d;
      o_ill_q   <= o_ill_d;
      k_valid_q <= k_valid_d;
      k_imm_q   <= k_imm_d;
      k_tag_q   <= k_tag_d;
      k_ill_q   <= k_ill_d;
    end
  end

  assign in_ready    = !k_valid_q;
  assign out_valid   = o_valid_q;
  assign out_imm     = o_imm_q;
  assign out_tag     = o_tag_q;
  assign out_illegal = o_ill_q;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed bench: an RV32 explicit-format instance and an RV64 auto-decode
// instance share one stimulus stream. Honours IMM_GEN_ZIMM_EN if defined.
module tb_imm_gen_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_instr;
  logic [2:0]  in_imm_src;
  logic [31:0] in_tag;

  logic        a_in_ready, a_out_valid, a_out_illegal;
  logic [31:0] a_out_imm, a_out_tag;
  logic        b_in_ready, b_out_valid, b_out_illegal;
  logic [63:0] b_out_imm;
  logic [31:0] b_out_tag;

  int n_checks = 0;
  int n_pass   = 0;

`ifdef IMM_GEN_ZIMM_EN
  localparam logic [31:0] Z_A = 32'h0000001F;
  localparam logic [63:0] Z_B = 64'h000000000000001F;
`else
  localparam logic [31:0] Z_A = 32'h00000000;
  localparam logic [63:0] Z_B = 64'h0000000000000300;
`endif

  always #5 clk = ~clk;

  imm_gen_stage #(.XLEN(32), .TAG_W(32), .AUTO_DECODE(0)) u_a (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_instr(in_instr), .in_imm_src(in_imm_src), .in_tag(in_tag),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_imm(a_out_imm),
    .out_tag(a_out_tag), .out_illegal(a_out_illegal)
  );

  imm_gen_stage #(.XLEN(64), .TAG_W(32), .AUTO_DECODE(1)) u_b (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_instr(in_instr), .in_imm_src(in_imm_src), .in_tag(in_tag),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_imm(b_out_imm),
    .out_tag(b_out_tag), .out_illegal(b_out_illegal)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic expect_out(input string name, input logic valid, input logic [31:0] a_imm,
                            input logic [63:0] b_imm, input logic b_ill, input logic [31:0] tag);
    check({name, "/a_valid"}, {63'd0, a_out_valid}, {63'd0, valid});
    check({name, "/b_valid"}, {63'd0, b_out_valid}, {63'd0, valid});
    if (valid) begin
      check({name, "/a_imm"}, {32'd0, a_out_imm}, {32'd0, a_imm});
      check({name, "/b_imm"}, b_out_imm, b_imm);
      check({name, "/a_ill"}, {63'd0, a_out_illegal}, 64'd0);
      check({name, "/b_ill"}, {63'd0, b_out_illegal}, {63'd0, b_ill});
      check({name, "/a_tag"}, {32'd0, a_out_tag}, {32'd0, tag});
      check({name, "/b_tag"}, {32'd0, b_out_tag}, {32'd0, tag});
    end
  endtask

  task automatic expect_reset(input string name);
    check({name, "/a_valid"}, {63'd0, a_out_valid}, 64'd0);
    check({name, "/a_imm"}, {32'd0, a_out_imm}, 64'd0);
    check({name, "/a_tag"}, {32'd0, a_out_tag}, 64'd0);
    check({name, "/a_ill"}, {63'd0, a_out_illegal}, 64'd0);
    check({name, "/a_ready"}, {63'd0, a_in_ready}, 64'd1);
    check({name, "/b_valid"}, {63'd0, b_out_valid}, 64'd0);
    check({name, "/b_imm"}, b_out_imm, 64'd0);
    check({name, "/b_ill"}, {63'd0, b_out_illegal}, 64'd0);
    check({name, "/b_ready"}, {63'd0, b_in_ready}, 64'd1);
  endtask

  task automatic set_in(input logic [31:0] instr, input logic [2:0] src, input logic [31:0] tag);
    in_valid   = 1'b1;
    in_instr   = instr;
    in_imm_src = src;
    in_tag     = tag;
  endtask

  task automatic drive(input logic [31:0] instr, input logic [2:0] src, input logic [31:0] tag);
    set_in(instr, src, tag);
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_instr = 32'd0; in_imm_src = 3'd0; in_tag = 32'd0;
    step();
    step();
    expect_reset("reset");
    rst = 1'b0;

    // Back-to-back entries with out_ready high; each appears one cycle after acceptance.
    drive(32'hFE000EE3, 3'b010, 32'h1);
    expect_out("fmt_b", 1'b1, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0, 32'h1);
    drive(32'hFF9FF06F, 3'b011, 32'h2);
    expect_out("fmt_j", 1'b1, 32'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8, 1'b0, 32'h2);
    drive(32'h800000B7, 3'b100, 32'h3);
    expect_out("fmt_u", 1'b1, 32'h80000000, 64'hFFFFFFFF80000000, 1'b0, 32'h3);
    drive(32'hFFF00093, 3'b000, 32'h4);
    expect_out("fmt_i", 1'b1, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0, 32'h4);
    drive(32'h0000007F, 3'b111, 32'h5);
    expect_out("illegal", 1'b1, 32'h00000000, 64'h0, 1'b1, 32'h5);
    drive(32'h300FD073, 3'b101, 32'h6);
    expect_out("fmt_z", 1'b1, Z_A, Z_B, 1'b0, 32'h6);
    drive(32'h43F0D093, 3'b110, 32'h7);
    expect_out("shamt", 1'b1, 32'h0000001F, 64'h000000000000003F, 1'b0, 32'h7);
    drive(32'hFE112E23, 3'b001, 32'h8);
    expect_out("fmt_s", 1'b1, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0, 32'h8);
    step();
    expect_out("drained", 1'b0, 32'h0, 64'h0, 1'b0, 32'h0);

    // Backpressure: A into O, B into K, C held off.
    out_ready = 1'b0;
    set_in(32'h00100093, 3'b000, 32'hA);
    step();
    check("bp/ready_after_a", {63'd0, a_in_ready}, 64'd1);
    set_in(32'h00200093, 3'b000, 32'hB);
    step();
    check("bp/ready_k_full", {63'd0, a_in_ready}, 64'd0);
    set_in(32'h00300093, 3'b000, 32'hC);
    step();
    expect_out("bp/hold_a", 1'b1, 32'h1, 64'h1, 1'b0, 32'hA);
    check("bp/a_ready_held", {63'd0, a_in_ready}, 64'd0);
    check("bp/b_ready_held", {63'd0, b_in_ready}, 64'd0);
    out_ready = 1'b1;
    step();
    expect_out("bp/out_b", 1'b1, 32'h2, 64'h2, 1'b0, 32'hB);
    check("bp/ready_drained", {63'd0, a_in_ready}, 64'd1);
    step();
    expect_out("bp/out_c", 1'b1, 32'h3, 64'h3, 1'b0, 32'hC);
    in_valid = 1'b0;
    step();
    expect_out("bp/empty", 1'b0, 32'h0, 64'h0, 1'b0, 32'h0);

    // Flush discards a same-cycle handshake into an empty stage.
    set_in(32'h00900093, 3'b000, 32'h20);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    expect_out("flush_hs", 1'b0, 32'h0, 64'h0, 1'b0, 32'h0);
    step();
    expect_out("flush_hs_after", 1'b0, 32'h0, 64'h0, 1'b0, 32'h0);

    // Flush with O and K full and a pending input.
    out_ready = 1'b0;
    set_in(32'h01100093, 3'b000, 32'h11);
    step();
    set_in(32'h01200093, 3'b000, 32'h12);
    step();
    set_in(32'h01300093, 3'b000, 32'h13);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    expect_out("flush_full", 1'b0, 32'h0, 64'h0, 1'b0, 32'h0);
    check("flush_full/a_ready", {63'd0, a_in_ready}, 64'd1);
    check("flush_full/b_ready", {63'd0, b_in_ready}, 64'd1);
    out_ready = 1'b1;
    step();
    expect_out("flush_full_after", 1'b0, 32'h0, 64'h0, 1'b0, 32'h0);

    // Reset mid-stream, then first entry after release.
    out_ready = 1'b0;
    drive(32'hFFF00093, 3'b000, 32'h55);
    expect_out("pre_rst", 1'b1, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0, 32'h55);
    set_in(32'h00700093, 3'b000, 32'h56);
    rst = 1'b1;
    step();
    in_valid = 1'b0;
    expect_reset("mid_rst");
    rst = 1'b0;
    out_ready = 1'b1;
    drive(32'h00500093, 3'b000, 32'h77);
    expect_out("post_rst", 1'b1, 32'h5, 64'h5, 1'b0, 32'h77);
    step();
    expect_out("post_rst_empty", 1'b0, 32'h0, 64'h0, 1'b0, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
